// File: rtl/periph_bus.sv
// periph_bus: MEM-stage memory-mapped timer, LED/7-segment, switch and tick-counter block.
// Define PERIPH_SYSTICK_EN to build the free-running SYSTICK counter at offset 0x14.
module periph_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        IRQ,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    input  logic [7:0]  switches
);

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LED     = 3'd3,
        REG_DIGITS  = 3'd4,
        REG_SYSTICK = 3'd5,
        REG_SWITCH  = 3'd6,
        REG_RSVD    = 3'd7
    } reg_idx_e;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digits_q, digits_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] systick;
    reg_idx_e    idx;
    logic        wr_en;
    logic        unused_addr_lsbs;

    assign Hit              = (Address[31:5] == BASE_ADDR[31:5]);
    assign idx              = reg_idx_e'(Address[4:2]);
    assign wr_en            = MemWrite && Hit;
    assign unused_addr_lsbs = ^Address[1:0];

    assign IRQ    = tcon_q[1] & tcon_q[2];
    assign leds   = led_q;
    assign digits = digits_q;

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && Hit) begin
            case (idx)
                REG_TH:      ReadData = th_q;
                REG_TL:      ReadData = tl_q;
                REG_TCON:    ReadData = {29'h0, tcon_q};
                REG_LED:     ReadData = {24'h0, led_q};
                REG_DIGITS:  ReadData = {20'h0, digits_q};
                REG_SYSTICK: ReadData = systick;
                REG_SWITCH:  ReadData = {24'h0, sw_sync_q};
                default:     ReadData = 32'h0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no latch is inferred.
        th_d     = th_q;
        tl_d     = tl_q;
        tcon_d   = tcon_q;
        led_d    = led_q;
        digits_d = digits_q;

        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) tcon_d[2] = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        // CPU writes override the timer; a TL write also cancels that edge's status set.
        if (wr_en) begin
            case (idx)
                REG_TH:     th_d = WriteData;
                REG_TL: begin
                    tl_d   = WriteData;
                    tcon_d = tcon_q;
                end
                REG_TCON:   tcon_d   = WriteData[2:0];
                REG_LED:    led_d    = WriteData[7:0];
                REG_DIGITS: digits_d = WriteData[11:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            tcon_q    <= 3'h0;
            led_q     <= 8'h0;
            digits_q  <= 12'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            // NOTE: non-blocking so both synchroniser stages sample pre-edge values.
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digits_q  <= digits_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) systick_q <= 32'h0;
        else        systick_q <= systick_q + 32'd1;
    end

    assign systick = systick_q;
`else
    assign systick = 32'h0;
`endif

endmodule

// File: tb/tb_periph_bus.sv
// Randomised and directed bench for periph_bus against a cycle-level behavioural model.
module tb_periph_bus;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_DIG  = BASE + 32'h10;
    localparam logic [31:0] A_TICK = BASE + 32'h14;
    localparam logic [31:0] A_SW   = BASE + 32'h18;
    localparam logic [31:0] A_RSV  = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        IRQ;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic [7:0]  switches = 8'h0;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led, m_s1, m_s2;
    logic [11:0] m_dig;

    periph_bus #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Hit(Hit), .IRQ(IRQ), .leds(leds), .digits(digits), .switches(switches)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_dig = 0;
        m_s1 = 0; m_s2 = 0; m_tick = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0:    return m_th;
            3'd1:    return m_tl;
            3'd2:    return {29'h0, m_tcon};
            3'd3:    return {24'h0, m_led};
            3'd4:    return {20'h0, m_dig};
`ifdef PERIPH_SYSTICK_EN
            3'd5:    return m_tick;
`endif
            3'd6:    return {24'h0, m_s2};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs, advance one edge with the model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic        hit;
        logic [31:0] n_th, n_tl;
        logic [2:0]  n_tcon;
        logic [7:0]  n_led;
        logic [11:0] n_dig;
        MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
        #2;
        hit = (a[31:5] == BASE[31:5]);
        check("hit", {31'h0, Hit}, {31'h0, hit});
        check("rdata", ReadData, rd ? model_read(a) : 32'h0);
        check("irq", {31'h0, IRQ}, {31'h0, m_tcon[1] & m_tcon[2]});
        check("leds", {24'h0, leds}, {24'h0, m_led});
        check("digits", {20'h0, digits}, {20'h0, m_dig});

        n_th = m_th; n_tl = m_tl; n_tcon = m_tcon; n_led = m_led; n_dig = m_dig;
        if (wr && hit && a[4:2] == 3'd1) begin
            n_tl = d;
        end else if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                n_tl = m_th;
                if (m_tcon[1]) n_tcon[2] = 1'b1;
            end else begin
                n_tl = m_tl + 1;
            end
        end
        if (wr && hit) begin
            case (a[4:2])
                3'd0: n_th = d;
                3'd2: n_tcon = d[2:0];
                3'd3: n_led = d[7:0];
                3'd4: n_dig = d[11:0];
                default: ;
            endcase
        end
        @(posedge clk);
        m_s2 = m_s1; m_s1 = switches;
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_led = n_led; m_dig = n_dig;
        m_tick = m_tick + 1;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        access(1'b0, 1'b1, a, d);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, A_RSV, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; MemWrite = 1'b0; Address = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  r;
        model_reset();
        #2;
        check("rst_rdata", ReadData, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_digits", {20'h0, digits}, 32'h0);
        #10 reset = 1'b1;

        for (int i = 0; i < 100; i++) access(1'b1, 1'b0, A_TICK, 32'h0);
`ifdef PERIPH_SYSTICK_EN
        peek("systick_100", A_TICK, 32'd100);
`else
        peek("systick_off", A_TICK, 32'h0);
`endif

        // Register read/write, RO and reserved offsets.
        wr(A_LED, 32'h1234_5678);
        check("led_out", {24'h0, leds}, 32'h78);
        peek("led_rd", A_LED, 32'h0000_0078);
        wr(A_TICK, 32'h55);
        peek("tick_ro", A_TICK, model_read(A_TICK));
        wr(A_SW, 32'hFF);
        peek("sw_ro", A_SW, 32'h0);
        peek("rsvd_rd", A_RSV, 32'h0);

        // Timer wrap with interrupt.
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TCON, 32'h3);
        wr(A_TL, 32'hFFFF_FFFE);
        peek("tl_load", A_TL, 32'hFFFF_FFFE);
        idle();
        peek("tl_ff", A_TL, 32'hFFFF_FFFF);
        idle();
        peek("tl_reload", A_TL, 32'hFFFF_FFF0);
        peek("tcon_stat", A_TCON, 32'h7);
        check("irq_set", {31'h0, IRQ}, 32'h1);
        wr(A_TCON, 32'h3);
        check("irq_clr", {31'h0, IRQ}, 32'h0);

        // TL write on the wrap edge.
        wr(A_TL, 32'hFFFF_FFFE);
        idle();
        peek("col_tl_pre", A_TL, 32'hFFFF_FFFF);
        wr(A_TL, 32'h7);
        peek("col_tl", A_TL, 32'h7);
        peek("col_tl_tcon", A_TCON, 32'h3);

        // TCON write on a status-setting edge.
        wr(A_TL, 32'hFFFF_FFFE);
        idle();
        wr(A_TCON, 32'h3);
        peek("col_tcon", A_TCON, 32'h3);
        peek("col_tcon_tl", A_TL, 32'hFFFF_FFF0);
        check("col_tcon_irq", {31'h0, IRQ}, 32'h0);

        // TH write on the wrap edge reloads the old TH.
        wr(A_TL, 32'hFFFF_FFFE);
        idle();
        wr(A_TH, 32'h100);
        peek("col_th_tl", A_TL, 32'hFFFF_FFF0);
        peek("col_th_th", A_TH, 32'h100);
        wr(A_TCON, 32'h0);

        // Address decode edges.
        wr(BASE + 32'h20, 32'hDEAD_BEEF);
        wr(32'h3FFF_FFFC, 32'hDEAD_BEEF);
        Address = BASE + 32'h20; #1;
        check("hit_above", {31'h0, Hit}, 32'h0);
        Address = 32'h3FFF_FFFC; #1;
        check("hit_below", {31'h0, Hit}, 32'h0);
        peek("dec_th", A_TH, 32'h100);
        peek("dec_led", A_LED, 32'h78);
        wr(BASE + 32'h3, 32'hCAFE_F00D);
        peek("dec_lsb", A_TH, 32'hCAFE_F00D);

        // Switch synchroniser latency.
        switches = 8'h00;
        idle(); idle(); idle();
        switches = 8'h5A;
        idle();
        peek("sw_1edge", A_SW, 32'h0);
        idle();
        peek("sw_2edge", A_SW, 32'h5A);

        // Asynchronous reset mid-operation.
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'h5);
        wr(A_LED, 32'hAA);
        wr(A_DIG, 32'hFFF);
        wr(A_TCON, 32'h6);
        peek("pre_rst_tl", A_TL, 32'h5);
        check("pre_rst_irq", {31'h0, IRQ}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_rdata", ReadData, 32'h0);
        check("rst_async_irq", {31'h0, IRQ}, 32'h0);
        check("rst_async_leds", {24'h0, leds}, 32'h0);
        check("rst_async_digits", {20'h0, digits}, 32'h0);
        model_reset();
        #1 reset = 1'b1;
        peek("post_rst_tl", A_TL, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) switches = 8'($urandom);
            r = 3'($urandom);
            if ($urandom_range(9) == 0) a = $urandom;
            else a = BASE | {27'h0, r, 2'($urandom)};
            d = $urandom;
            if (r == 3'd1 && $urandom_range(1) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            if (r == 3'd0 && $urandom_range(1) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            access(1'($urandom), 1'($urandom), a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
